// File: rtl/mac_accumulator_if.sv
// rtl/mac_accumulator_if.sv - operand/result stream bundle for mac_accumulator
// MAC_BIAS_EN adds the per-vector in_bias operand.
interface mac_accumulator_if #(
  parameter int IL = 8,
  parameter int FL = 12
);
  localparam int W  = IL + FL;
  localparam int AW = 4 + 2 * W;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic          in_last;
`ifdef MAC_BIAS_EN
  logic [W-1:0]  in_bias;
`endif
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] acc_out;
  logic          out_trunc;

`ifdef MAC_BIAS_EN
  modport master (
    output in_valid, in_a, in_b, in_last, in_bias, out_ready,
    input  in_ready, out_valid, acc_out, out_trunc
  );
  modport slave (
    input  in_valid, in_a, in_b, in_last, in_bias, out_ready,
    output in_ready, out_valid, acc_out, out_trunc
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, acc_out, out_trunc
  );
  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, acc_out, out_trunc
  );
`endif
endinterface

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - streaming signed fixed-point multiply-accumulate over 1..MAX_TERMS terms
// MAC_BIAS_EN: acc of each vector starts from in_bias aligned to the 2FL product fraction.
module mac_accumulator #(
  parameter int IL        = 8,
  parameter int FL        = 12,
  parameter int MAX_TERMS = 16
) (
  input logic               clk,
  input logic               reset,
  mac_accumulator_if.slave  bus
);
  localparam int W  = IL + FL;
  localparam int PW = 2 * W;
  localparam int AW = 4 + PW;
  localparam int CW = $clog2(MAX_TERMS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t         state, state_next;
  logic [PW-1:0]  prod;
  logic           prod_valid;
  logic [AW-1:0]  acc;
  logic [CW-1:0]  count;
  logic           trunc;

  logic           accept;
  logic           close;
  logic           trunc_hit;
  logic [CW-1:0]  count_next;
  logic [PW-1:0]  a_ext, b_ext, prod_full;
  logic [AW-1:0]  prod_ext, bias_ext;

  assign accept     = bus.in_valid && bus.in_ready;
  assign count_next = count + CW'(1);
  assign trunc_hit  = (count_next == CW'(MAX_TERMS)) && !bus.in_last;
  assign close      = bus.in_last || (count_next == CW'(MAX_TERMS));

  // Low PW bits of the product of sign-extended operands are the exact signed product.
  assign a_ext     = {{W{bus.in_a[W-1]}}, bus.in_a};
  assign b_ext     = {{W{bus.in_b[W-1]}}, bus.in_b};
  assign prod_full = a_ext * b_ext;
  assign prod_ext  = {{4{prod[PW-1]}}, prod};

`ifdef MAC_BIAS_EN
  assign bias_ext = {{(4 + IL){bus.in_bias[W-1]}}, bus.in_bias, {FL{1'b0}}};
`else
  assign bias_ext = '0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_next = close ? DRAIN : ACCUM;
      end
      DRAIN: state_next = OUT;
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prod       <= '0;
      prod_valid <= 1'b0;
      acc        <= '0;
      count      <= '0;
      trunc      <= 1'b0;
    end else begin
      prod_valid <= accept;
      if (accept) begin
        prod  <= prod_full;
        count <= count_next;
        trunc <= trunc_hit;
      end
      // prod_valid is never set in IDLE, so the first accept just seeds acc.
      if (state == IDLE && accept) begin
        acc <= bias_ext;
      end else if (prod_valid) begin
        acc <= acc + prod_ext;
      end
      if (state == OUT && bus.out_ready) begin
        acc   <= '0;
        count <= '0;
        trunc <= 1'b0;
      end
    end
  end

  assign bus.acc_out   = acc;
  assign bus.out_trunc = trunc && bus.out_valid;
endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - directed self-checking bench for mac_accumulator (IL=8, FL=12)
// Build with MAC_BIAS_EN defined to exercise the bias path.
module tb_mac_accumulator;
  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  mac_accumulator_if #(.IL(8), .FL(12)) bus ();

  mac_accumulator #(.IL(8), .FL(12), .MAX_TERMS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [43:0] e44(input longint v);
    return v[43:0];
  endfunction

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk44(input string tag, input logic [43:0] obs, input logic [43:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic drive(input int a, input int b, input logic last);
    bus.in_valid = 1'b1;
    bus.in_a     = a[19:0];
    bus.in_b     = b[19:0];
    bus.in_last  = last;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic finish_vec();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    longint bias_exp;
    n_assert      = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
`ifdef MAC_BIAS_EN
    bus.in_bias   = '0;
`endif
    repeat (2) @(negedge clk);
    chk1 ("rst_in_ready",  bus.in_ready,  1'b1);
    chk1 ("rst_out_valid", bus.out_valid, 1'b0);
    chk1 ("rst_out_trunc", bus.out_trunc, 1'b0);
    chk44("rst_acc",       bus.acc_out,   e44(0));
    reset = 1'b1;
    step();

    // 4 x (2.0 * 1.0) -> 8.0, result valid the second edge after the last accept
    for (int i = 0; i < 4; i++) begin
      chk1("t1_in_ready", bus.in_ready, 1'b1);
      drive(4096, 8192, i == 3);
      step();
    end
    bus.in_valid = 1'b0;
    chk1 ("t1_drain_valid", bus.out_valid, 1'b0);
    chk1 ("t1_drain_ready", bus.in_ready,  1'b0);
    step();
    chk1 ("t1_out_valid", bus.out_valid, 1'b1);
    chk44("t1_acc",       bus.acc_out,   e44(134217728));
    chk1 ("t1_trunc",     bus.out_trunc, 1'b0);
    finish_vec();
    chk1 ("t1_post_valid", bus.out_valid, 1'b0);
    chk1 ("t1_post_ready", bus.in_ready,  1'b1);

    // single negative term
    drive(-6144, 8192, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    chk1 ("t2_out_valid", bus.out_valid, 1'b1);
    chk44("t2_acc",       bus.acc_out,   e44(-50331648));
    finish_vec();

    // 16 maximal products without last: saturating close, 17th pair refused
    for (int i = 0; i < 16; i++) begin
      drive(-524288, -524288, 1'b0);
      step();
    end
    chk1 ("t3_no_17th", bus.in_ready, 1'b0);
    step();
    chk1 ("t3_out_valid", bus.out_valid, 1'b1);
    chk44("t3_acc",       bus.acc_out,   e44(longint'(1) << 42));
    chk1 ("t3_trunc",     bus.out_trunc, 1'b1);
    step();
    chk44("t3_acc_hold",  bus.acc_out,   e44(longint'(1) << 42));
    bus.in_valid = 1'b0;
    finish_vec();

    // in_last on the 16th term closes normally
    for (int i = 0; i < 16; i++) begin
      drive(4096, 4096, i == 15);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    chk44("t3b_acc",   bus.acc_out,   e44(268435456));
    chk1 ("t3b_trunc", bus.out_trunc, 1'b0);
    finish_vec();

    // output stalled with garbage pairs offered: everything holds
    drive(4096, 4096, 1'b1);
    step();
    drive(1234, 5678, 1'b1);
    step();
    for (int i = 0; i < 10; i++) begin
      chk1 ("t4_hold_valid", bus.out_valid, 1'b1);
      chk44("t4_hold_acc",   bus.acc_out,   e44(16777216));
      chk1 ("t4_hold_ready", bus.in_ready,  1'b0);
      step();
    end
    bus.in_valid = 1'b0;
    finish_vec();
    drive(4096, 8192, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    chk44("t4_next_acc", bus.acc_out, e44(33554432));
    finish_vec();

    // asynchronous reset in the middle of a vector
    for (int i = 0; i < 3; i++) begin
      drive(4096, 4096, 1'b0);
      step();
    end
    bus.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk1 ("t5_rst_valid", bus.out_valid, 1'b0);
    chk1 ("t5_rst_ready", bus.in_ready,  1'b1);
    chk44("t5_rst_acc",   bus.acc_out,   e44(0));
    @(negedge clk);
    reset = 1'b1;
    drive(4096, 4096, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    chk44("t5_acc", bus.acc_out, e44(16777216));
    finish_vec();

    // bias seeds the accumulator only when the feature is built in
`ifdef MAC_BIAS_EN
    bus.in_bias = 20'd4096;
    bias_exp    = 33554432;
`else
    bias_exp    = 16777216;
`endif
    drive(4096, 4096, 1'b1);
    step();
    bus.in_valid = 1'b0;
    step();
    chk1 ("t6_out_valid", bus.out_valid, 1'b1);
    chk44("t6_acc",       bus.acc_out,   e44(bias_exp));
    finish_vec();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
